// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: forwarding select codes,
// hazard-control FSM encoding and the bubble instruction.
package core_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'd0;  // register file read data
  localparam logic [1:0] FWD_MEM = 2'd1;  // ex_mem alu_out
  localparam logic [1:0] FWD_WB  = 2'd2;  // mem_wb writeback result

  // Hazard-control FSM states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } hz_state_e;

  // addi x0, x0, 0: loaded into a stage register when it is flushed
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register.
// The youngest in-flight producer (ex_mem) wins over mem_wb; x0 never forwards.
module fwd_unit
  import core_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_we,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_we,
  output logic [1:0] o_sel
);

  // Priority select: ex_mem result, then mem_wb result, else register file
  always_comb begin
    // NOTE: default assignment first so every path drives o_sel and no latch is inferred.
    o_sel = FWD_RF;
    if (i_src != 5'd0) begin
      if (i_mem_we && (i_mem_rd == i_src))
        o_sel = FWD_MEM;
      else if (i_wb_we && (i_wb_rd == i_src))
        o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32I core: stage enables and
// flushes, EX forwarding selects, data-memory handshake, memory-wait
// watchdog and hazard performance counters.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_num,
  input  logic [4:0]       id_rs2_num,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1_num,
  input  logic [4:0]       ex_rs2_num,
  input  logic [4:0]       ex_rd_num,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd_num,
  input  logic [4:0]       wb_rd_num,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mem_op,
  input  logic             dmem_ready,
  output logic             dmem_valid,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel_branch,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  input  logic             ctr_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_e         r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_load_use_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_dmem_valid;
  logic w_mem_stall;
  logic w_branch;
  logic w_lu_match;
  logic w_load_use;

  // Any load writes rd, so the load-use check keys on ex_is_load alone.
  logic w_unused;
  assign w_unused = ex_reg_write;

  // Hazard classification, in priority order: memory stall, branch, load-use
  always_comb begin
    w_dmem_valid = mem_op && (r_state != ST_FAULT);
    w_mem_stall  = (w_dmem_valid && !dmem_ready) || (r_state == ST_FAULT);
    w_branch     = ex_branch_taken && !w_mem_stall;
    w_lu_match   = ex_is_load && (ex_rd_num != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1_num == ex_rd_num)) ||
                    (id_uses_rs2 && (id_rs2_num == ex_rd_num)));
    w_load_use   = w_lu_match && !w_mem_stall && !ex_branch_taken;
  end

  // Stage enables and flushes derived from the active hazard
  always_comb begin
    dmem_valid    = w_dmem_valid;
    pc_en         = !w_mem_stall && !w_load_use;
    if_id_en      = !w_mem_stall && !w_load_use;
    id_ex_en      = !w_mem_stall;
    ex_mem_en     = !w_mem_stall;
    if_id_flush   = w_branch;
    id_ex_flush   = w_branch || w_load_use;
    mem_wb_flush  = w_mem_stall;
    pc_sel_branch = w_branch;
  end

  fwd_unit u_fwd_a (
    .i_src    (ex_rs1_num),
    .i_mem_rd (mem_rd_num),
    .i_mem_we (mem_reg_write),
    .i_wb_rd  (wb_rd_num),
    .i_wb_we  (wb_reg_write),
    .o_sel    (fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src    (ex_rs2_num),
    .i_mem_rd (mem_rd_num),
    .i_mem_we (mem_reg_write),
    .i_wb_rd  (wb_rd_num),
    .i_wb_we  (wb_reg_write),
    .o_sel    (fwd_b)
  );

  // Memory-wait FSM with watchdog; FAULT is sticky until rst
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wait_cnt <= '0;
          if (mem_op && !dmem_ready)
            r_state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            // Counter lands on TIMEOUT and stays there: it never wraps
            r_state    <= ST_FAULT;
            r_timeout  <= 1'b1;
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Hazard performance counters; clear beats increment, FAULT counts as stall
  always_ff @(posedge clk) begin
    if (rst || ctr_clr) begin
      r_stall_cycles <= '0;
      r_load_use_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_mem_stall || w_load_use)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_load_use)
        r_load_use_cnt <= r_load_use_cnt + CNT_W'(1);
      if (w_branch)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall_cycles;
  assign load_use_cnt = r_load_use_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Control vector order: pc_en, if_id_en, id_ex_en, ex_mem_en,
  //                       if_id_flush, id_ex_flush, mem_wb_flush, pc_sel_branch
  localparam logic [7:0] C_RUN    = 8'b1111_0000;
  localparam logic [7:0] C_STALL  = 8'b0000_0010;
  localparam logic [7:0] C_BRANCH = 8'b1111_1101;
  localparam logic [7:0] C_LOADU  = 8'b0011_0100;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1_num, id_rs2_num;
  logic             id_uses_rs1, id_uses_rs2;
  logic [4:0]       ex_rs1_num, ex_rs2_num, ex_rd_num;
  logic             ex_reg_write, ex_is_load, ex_branch_taken;
  logic [4:0]       mem_rd_num, wb_rd_num;
  logic             mem_reg_write, wb_reg_write;
  logic             mem_op, dmem_ready;
  logic             dmem_valid;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, pc_sel_branch;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_timeout;
  logic             ctr_clr;
  logic [CNT_W-1:0] stall_cycles, load_use_cnt, flush_cnt;
  logic [7:0]       ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                 if_id_flush, id_ex_flush, mem_wb_flush, pc_sel_branch};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_num      (id_rs1_num),
    .id_rs2_num      (id_rs2_num),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rs1_num      (ex_rs1_num),
    .ex_rs2_num      (ex_rs2_num),
    .ex_rd_num       (ex_rd_num),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd_num      (mem_rd_num),
    .wb_rd_num       (wb_rd_num),
    .mem_reg_write   (mem_reg_write),
    .wb_reg_write    (wb_reg_write),
    .mem_op          (mem_op),
    .dmem_ready      (dmem_ready),
    .dmem_valid      (dmem_valid),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
    .pc_sel_branch   (pc_sel_branch),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mem_timeout     (mem_timeout),
    .ctr_clr         (ctr_clr),
    .stall_cycles    (stall_cycles),
    .load_use_cnt    (load_use_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic idle();
    id_rs1_num = 0; id_rs2_num = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1_num = 0; ex_rs2_num = 0; ex_rd_num = 0;
    ex_reg_write = 0; ex_is_load = 0; ex_branch_taken = 0;
    mem_rd_num = 0; wb_rd_num = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_op = 0; dmem_ready = 0; ctr_clr = 0;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrs();
    ctr_clr = 1'b1;
    step();
    ctr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mem_op = 1'b1; dmem_ready = 1'b1;
    step(); step();
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RUN); end
    n_checks++; if (dmem_valid !== 1'b1) begin n_fail++; $display("FAIL reset_dmem_valid: got %b want 1", dmem_valid); end
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
    n_checks++; if ({stall_cycles, load_use_cnt, flush_cnt} !== '0) begin n_fail++; $display("FAIL reset_ctrs: got %0d/%0d/%0d want 0/0/0", stall_cycles, load_use_cnt, flush_cnt); end
    mem_op = 1'b0;
    #1;
    n_checks++; if (dmem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_idle: got %b want 0", dmem_valid); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_forwarding();
    idle();
    ex_rs1_num = 5; ex_rs2_num = 9;
    mem_rd_num = 5; mem_reg_write = 1; wb_rd_num = 5; wb_reg_write = 1;
    #1;
    n_checks++; if (fwd_a !== 2'd1) begin n_fail++; $display("FAIL fwd_mem_prio: got %0d want 1", fwd_a); end
    n_checks++; if (fwd_b !== 2'd0) begin n_fail++; $display("FAIL fwd_b_nomatch: got %0d want 0", fwd_b); end
    mem_reg_write = 0; ex_rs2_num = 5;
    #1;
    n_checks++; if (fwd_a !== 2'd2) begin n_fail++; $display("FAIL fwd_wb_only: got %0d want 2", fwd_a); end
    n_checks++; if (fwd_b !== 2'd2) begin n_fail++; $display("FAIL fwd_b_wb: got %0d want 2", fwd_b); end
    mem_reg_write = 1; mem_rd_num = 3; ex_rs2_num = 3;
    #1;
    n_checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin n_fail++; $display("FAIL fwd_split: got %0d/%0d want 2/1", fwd_a, fwd_b); end
    ex_rs1_num = 0; ex_rs2_num = 0; mem_rd_num = 0; wb_rd_num = 0;
    #1;
    n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0: got %0d/%0d want 0/0", fwd_a, fwd_b); end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    clear_ctrs();
    ex_is_load = 1; ex_reg_write = 1; ex_rd_num = 7;
    id_uses_rs1 = 1; id_rs1_num = 7;
    #1;
    n_checks++; if (ctrl !== C_LOADU) begin n_fail++; $display("FAIL lu_bubble: got %b want %b", ctrl, C_LOADU); end
    step();
    // Load now in MEM (single-cycle access), dependent instruction in EX
    idle();
    mem_rd_num = 7; mem_reg_write = 1; mem_op = 1; dmem_ready = 1;
    ex_rs1_num = 7;
    #1;
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("FAIL lu_release: got %b want %b", ctrl, C_RUN); end
    n_checks++; if (fwd_a !== 2'd1) begin n_fail++; $display("FAIL lu_fwd: got %0d want 1", fwd_a); end
    n_checks++; if (load_use_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", load_use_cnt); end
    n_checks++; if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cycles); end
    // Boundary cases, combinational only
    idle();
    ex_is_load = 1; ex_reg_write = 1; ex_rd_num = 0; id_uses_rs1 = 1; id_rs1_num = 0;
    #1;
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("FAIL lu_x0: got %b want %b", ctrl, C_RUN); end
    ex_rd_num = 7; id_rs1_num = 7; id_uses_rs1 = 0;
    #1;
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("FAIL lu_unused_src: got %b want %b", ctrl, C_RUN); end
    id_rs1_num = 0; id_uses_rs2 = 1; id_rs2_num = 7;
    #1;
    n_checks++; if (ctrl !== C_LOADU) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", ctrl, C_LOADU); end
    idle();
    step();
  endtask

  task automatic test_branch_priority();
    idle();
    clear_ctrs();
    ex_is_load = 1; ex_reg_write = 1; ex_rd_num = 7; id_uses_rs1 = 1; id_rs1_num = 7;
    ex_branch_taken = 1;
    #1;
    n_checks++; if (ctrl !== C_BRANCH) begin n_fail++; $display("FAIL br_over_lu: got %b want %b", ctrl, C_BRANCH); end
    step();
    idle();
    #1;
    n_checks++; if ({flush_cnt, load_use_cnt, stall_cycles} !== {4'd1, 4'd0, 4'd0}) begin n_fail++; $display("FAIL br_ctrs: got flush=%0d lu=%0d stall=%0d want 1/0/0", flush_cnt, load_use_cnt, stall_cycles); end
  endtask

  task automatic test_mem_stall();
    idle();
    clear_ctrs();
    mem_op = 1; dmem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({ctrl, dmem_valid} !== {C_STALL, 1'b1}) begin n_fail++; $display("FAIL stall_cyc%0d: got %b/%b want %b/1", i, ctrl, dmem_valid, C_STALL); end
      step();
    end
    dmem_ready = 1;
    #1;
    n_checks++; if (ctrl !== C_BRANCH) begin n_fail++; $display("FAIL stall_release_br: got %b want %b", ctrl, C_BRANCH); end
    step();
    idle();
    #1;
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("FAIL stall_after: got %b want %b", ctrl, C_RUN); end
    n_checks++; if ({stall_cycles, flush_cnt} !== {4'd3, 4'd1}) begin n_fail++; $display("FAIL stall_ctrs: got stall=%0d flush=%0d want 3/1", stall_cycles, flush_cnt); end
  endtask

  task automatic test_timeout();
    idle();
    clear_ctrs();
    mem_op = 1; dmem_ready = 0;
    // One RUN detection cycle, then four MEM_WAIT cycles before FAULT
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early%0d: got %b want 0", i, mem_timeout); end
      step();
    end
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_rise: got %b want 1", mem_timeout); end
    mem_op = 0; dmem_ready = 1;
    #1;
    n_checks++; if ({ctrl, dmem_valid} !== {C_STALL, 1'b0}) begin n_fail++; $display("FAIL to_fault_ctrl: got %b/%b want %b/0", ctrl, dmem_valid, C_STALL); end
    mem_op = 1;
    #1;
    n_checks++; if (dmem_valid !== 1'b0) begin n_fail++; $display("FAIL to_fault_valid: got %b want 0", dmem_valid); end
    step(); step();
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", mem_timeout); end
    n_checks++; if (stall_cycles !== 4'd7) begin n_fail++; $display("FAIL to_stall_cnt: got %0d want 7", stall_cycles); end
    mem_op = 0;
    rst = 1; step(); rst = 0;
    #1;
    n_checks++; if ({mem_timeout, ctrl, stall_cycles} !== {1'b0, C_RUN, 4'd0}) begin n_fail++; $display("FAIL to_rst: got to=%b ctrl=%b stall=%0d want 0/%b/0", mem_timeout, ctrl, stall_cycles, C_RUN); end
    // Reset while in MEM_WAIT, then a fresh full timeout
    mem_op = 1; dmem_ready = 0;
    step(); step();
    rst = 1; step(); rst = 0;
    mem_op = 0;
    #1;
    n_checks++; if ({mem_timeout, ctrl} !== {1'b0, C_RUN}) begin n_fail++; $display("FAIL to_rst_midwait: got to=%b ctrl=%b want 0/%b", mem_timeout, ctrl, C_RUN); end
    mem_op = 1;
    repeat (4) step();
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_rewait_early: got %b want 0", mem_timeout); end
    step();
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_rewait_rise: got %b want 1", mem_timeout); end
    idle();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_counter_wrap();
    idle();
    clear_ctrs();
    ex_is_load = 1; ex_reg_write = 1; ex_rd_num = 7; id_uses_rs2 = 1; id_rs2_num = 7;
    repeat (15) step();
    n_checks++; if ({stall_cycles, load_use_cnt} !== {4'hF, 4'hF}) begin n_fail++; $display("FAIL wrap_full: got %0d/%0d want 15/15", stall_cycles, load_use_cnt); end
    step();
    n_checks++; if ({stall_cycles, load_use_cnt} !== {4'h0, 4'h0}) begin n_fail++; $display("FAIL wrap_zero: got %0d/%0d want 0/0", stall_cycles, load_use_cnt); end
    step();
    ctr_clr = 1; step(); ctr_clr = 0;
    n_checks++; if ({stall_cycles, load_use_cnt} !== {4'h0, 4'h0}) begin n_fail++; $display("FAIL clr_beats_inc: got %0d/%0d want 0/0", stall_cycles, load_use_cnt); end
    step();
    n_checks++; if ({stall_cycles, load_use_cnt} !== {4'h1, 4'h1}) begin n_fail++; $display("FAIL post_clr_inc: got %0d/%0d want 1/1", stall_cycles, load_use_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mem_stall();
    test_timeout();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
